// File: rtl/procesador_pkg.sv
// Shared processor definitions used by the data-memory arbiter.
//   arb_state_e  : data-RAM owner (CPU pipeline or host port)
//   DMEM_DATA_W  : default data RAM width
//   DMEM_ADDR_W  : default data RAM address width
package procesador_pkg;

    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_ADDR_W = 10;

    typedef enum logic {
        S_CPU  = 1'b0,
        S_HOST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter that measures how long a pending host request has
// been blocked by the CPU.
//   clk_sys  : clock
//   rst_b    : asynchronous active-low reset
//   clr      : synchronous clear (has priority over inc)
//   inc      : count one blocked cycle, saturating at MAX
//   max_hit  : count has reached MAX
module starve_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 4
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clr,
    input  logic inc,
    output logic max_hit
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != MAX_CNT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign max_hit = (count_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: shares the single data RAM between the pipeline MEM stage
// and a host load/debug port. The CPU owns the RAM by default; a latched host
// request gets a one-cycle slot when the CPU is idle or (with
// DMEM_ARB_STARVE_GUARD_EN defined) after STARVE_MAX blocked cycles. Without
// the macro the CPU has strict priority.
//
// Ports:
//   Clock, Reset                         : clock, async active-low reset
//   iCpuReq/iCpuWe/iCpuAddr/iCpuData     : MEM-stage access
//   oCpuStall                            : MEM access not performed this cycle
//   iHostReq/oHostReady                  : host request handshake
//   iHostWe/iHostAddr/iHostData          : host request fields
//   oHostDone/oHostRdData                : completion pulse and read data
//   oRamWe/oRamRAddr/oRamWAddr/oRamWData : RAM control
//   iRamRData                            : RAM asynchronous read data
//
// FSM states:
//   state  | meaning
//   S_CPU  | RAM driven by the MEM stage, host waits
//   S_HOST | one-cycle host access from the latch, CPU stalled if requesting
module dmem_arbiter
    import procesador_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iCpuReq,
    input  logic              iCpuWe,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuData,
    output logic              oCpuStall,
    input  logic              iHostReq,
    output logic              oHostReady,
    input  logic              iHostWe,
    input  logic [ADDR_W-1:0] iHostAddr,
    input  logic [DATA_W-1:0] iHostData,
    output logic              oHostDone,
    output logic [DATA_W-1:0] oHostRdData,
    output logic              oRamWe,
    output logic [ADDR_W-1:0] oRamRAddr,
    output logic [ADDR_W-1:0] oRamWAddr,
    output logic [DATA_W-1:0] oRamWData,
    input  logic [DATA_W-1:0] iRamRData
);

    arb_state_e        state_q;
    arb_state_e        state_d;

    logic              pend_q;
    logic              host_we_q;
    logic [ADDR_W-1:0] host_addr_q;
    logic [DATA_W-1:0] host_data_q;
    logic              done_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              host_accept;
    logic              starve_hit;
    logic [ADDR_W-1:0] ram_addr;

    assign host_accept = iHostReq & ~pend_q;
    assign oHostReady  = ~pend_q;
    assign oHostDone   = done_q;
    assign oHostRdData = rd_data_q;
    assign oRamRAddr   = ram_addr;
    assign oRamWAddr   = ram_addr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic starve_clr;
    logic starve_inc;

    assign starve_clr = ~pend_q | (state_q == S_HOST);
    assign starve_inc = pend_q & (state_q == S_CPU) & iCpuReq;

    starve_counter #(
        .WIDTH (4),
        .MAX   (STARVE_MAX)
    ) u_starve (
        .clk_sys (Clock),
        .rst_b   (Reset),
        .clr     (starve_clr),
        .inc     (starve_inc),
        .max_hit (starve_hit)
    );
`else
    // Strict CPU priority: the host only gets in on a CPU-idle cycle.
    logic unused_starve_cfg;
    assign unused_starve_cfg = ^STARVE_MAX;
    assign starve_hit        = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        oRamWe    = iCpuReq & iCpuWe;
        ram_addr  = iCpuAddr;
        oRamWData = iCpuData;
        oCpuStall = 1'b0;
        case (state_q)
            S_CPU: begin
                if (pend_q && (!iCpuReq || starve_hit)) begin
                    state_d = S_HOST;
                end
            end
            S_HOST: begin
                oRamWe    = host_we_q;
                ram_addr  = host_addr_q;
                oRamWData = host_data_q;
                oCpuStall = iCpuReq;
                state_d   = S_CPU;
            end
        endcase
    end

    // Host request latch. pend is always set during S_HOST, so a new request
    // cannot be accepted in the same edge that retires the current one.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pend_q      <= 1'b0;
            host_we_q   <= 1'b0;
            host_addr_q <= '0;
            host_data_q <= '0;
        end else if (state_q == S_HOST) begin
            pend_q <= 1'b0;
        end else if (host_accept) begin
            pend_q      <= 1'b1;
            host_we_q   <= iHostWe;
            host_addr_q <= iHostAddr;
            host_data_q <= iHostData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            done_q <= (state_q == S_HOST);
            if ((state_q == S_HOST) && !host_we_q) begin
                rd_data_q <= iRamRData;
            end
        end
    end

endmodule
